// File: rtl/data_memory.sv
// Byte-addressable little-endian data memory for the load/store path.
// One load port and one store port, each accepting a request every cycle.
// Loads return one cycle later with sign or zero extension. Stores are
// byte-masked. A load and a store to the same word in the same cycle
// return the post-store bytes (write-first). Misaligned or illegal-size
// accesses are flagged and have no effect on the array.
module data_memory #(
   parameter  int WIDTH  = 32,
   parameter  int DEPTH  = 16,
   localparam int ADDR_W = $clog2(DEPTH * WIDTH / 8)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              read_en_i,
   input  logic [ADDR_W-1:0] read_addr_i,
   input  logic [1:0]        read_size_i,
   input  logic              read_unsigned_i,
   output logic [WIDTH-1:0]  read_data_o,
   output logic              read_valid_o,
   output logic              read_error_o,
   input  logic              write_en_i,
   input  logic [ADDR_W-1:0] write_addr_i,
   input  logic [1:0]        write_size_i,
   input  logic [WIDTH-1:0]  write_data_i,
   output logic              write_error_o
);

   localparam int NB    = WIDTH / 8;
   localparam int OFF_W = $clog2(NB);
   localparam int IDX_W = ADDR_W - OFF_W;

   // Size is legal for this width and the offset is a multiple of the size.
   function automatic logic access_ok(input logic [1:0] size, input logic [OFF_W-1:0] off);
      logic [2:0] off_ext;
      logic [2:0] align_mask;
      logic       size_ok;
      off_ext = 3'(off);
      size_ok = 1'b1;
      case (size)
         2'd0: align_mask = 3'b000;
         2'd1: align_mask = 3'b001;
         2'd2: align_mask = 3'b011;
         2'd3: begin
            align_mask = 3'b111;
            if (WIDTH == 32) size_ok = 1'b0;
            else             size_ok = 1'b1;
         end
         default: begin
            align_mask = 3'b111;
            size_ok    = 1'b0;
         end
      endcase
      return size_ok && ((off_ext & align_mask) == 3'b000);
   endfunction

   // Byte lanes touched by an access of the given size at the given offset.
   function automatic logic [NB-1:0] lane_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
      logic [7:0]  base;
      logic [15:0] shifted;
      case (size)
         2'd0:    base = 8'h01;
         2'd1:    base = 8'h03;
         2'd2:    base = 8'h0F;
         2'd3:    base = 8'hFF;
         default: base = 8'h00;
      endcase
      shifted = {8'h00, base} << off;
      return shifted[NB-1:0];
   endfunction

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [WIDTH-1:0] read_data_q, read_data_d;
   logic             read_valid_q, read_valid_d;
   logic             read_error_q, read_error_d;
   logic             write_error_q, write_error_d;

   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [OFF_W-1:0] wr_off, rd_off;
   logic             wr_ok, rd_ok;
   logic [NB-1:0]    wr_mask;
   logic [WIDTH-1:0] wr_shift, wr_merge;
   logic [WIDTH-1:0] rd_word, rd_shift, rd_ext;
   logic             rd_sign;
   int               rd_bits;

   assign wr_idx  = write_addr_i[ADDR_W-1:OFF_W];
   assign wr_off  = write_addr_i[OFF_W-1:0];
   assign rd_idx  = read_addr_i[ADDR_W-1:OFF_W];
   assign rd_off  = read_addr_i[OFF_W-1:0];
   assign wr_ok   = write_en_i && access_ok(write_size_i, wr_off);
   assign rd_ok   = access_ok(read_size_i, rd_off);
   assign wr_mask = lane_mask(write_size_i, wr_off);

   // Next array contents: merge the shifted store bytes into the target word.
   always_comb begin
      mem_d    = mem_q;
      wr_shift = write_data_i << {wr_off, 3'b000};
      wr_merge = mem_q[wr_idx];
      for (int k = 0; k < NB; k++) begin
         if (wr_mask[k]) wr_merge[8*k +: 8] = wr_shift[8*k +: 8];
         else            wr_merge[8*k +: 8] = mem_q[wr_idx][8*k +: 8];
      end
      if (wr_ok) mem_d[wr_idx] = wr_merge;
      else       mem_d[wr_idx] = mem_q[wr_idx];
   end

   // Load path: read the post-store word (write-first), align, then extend.
   always_comb begin
      rd_word  = mem_d[rd_idx];
      rd_shift = rd_word >> {rd_off, 3'b000};
      case (read_size_i)
         2'd0:    begin rd_bits = 8;     rd_sign = rd_shift[7];       end
         2'd1:    begin rd_bits = 16;    rd_sign = rd_shift[15];      end
         2'd2:    begin rd_bits = 32;    rd_sign = rd_shift[31];      end
         2'd3:    begin rd_bits = WIDTH; rd_sign = rd_shift[WIDTH-1]; end
         default: begin rd_bits = WIDTH; rd_sign = 1'b0;              end
      endcase
      if (read_unsigned_i) rd_sign = 1'b0;
      else                 rd_sign = rd_sign;
      rd_ext = rd_shift;
      for (int i = 0; i < WIDTH; i++) begin
         if (i >= rd_bits) rd_ext[i] = rd_sign;
         else              rd_ext[i] = rd_shift[i];
      end
      read_valid_d  = read_en_i;
      read_error_d  = read_en_i && !rd_ok;
      write_error_d = write_en_i && !access_ok(write_size_i, wr_off);
      if (read_en_i) begin
         if (rd_ok) read_data_d = rd_ext;
         else       read_data_d = {WIDTH{1'b0}};
      end else begin
         read_data_d = read_data_q;
      end
   end

   // State update; reset clears the array and drops same-cycle requests.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
         read_data_q   <= {WIDTH{1'b0}};
         read_valid_q  <= 1'b0;
         read_error_q  <= 1'b0;
         write_error_q <= 1'b0;
      end else begin
         mem_q         <= mem_d;
         read_data_q   <= read_data_d;
         read_valid_q  <= read_valid_d;
         read_error_q  <= read_error_d;
         write_error_q <= write_error_d;
      end
   end

   assign read_data_o   = read_data_q;
   assign read_valid_o  = read_valid_q;
   assign read_error_o  = read_error_q;
   assign write_error_o = write_error_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory (WIDTH=32, DEPTH=16).
// Directed scenarios carry hand-derived expectations; a random phase uses a
// byte-array reference model. Load expectations go through a scoreboard queue.
module tb_data_memory;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        read_en_i = 1'b0;
   logic [5:0]  read_addr_i = 6'd0;
   logic [1:0]  read_size_i = 2'd0;
   logic        read_unsigned_i = 1'b0;
   logic [31:0] read_data_o;
   logic        read_valid_o;
   logic        read_error_o;
   logic        write_en_i = 1'b0;
   logic [5:0]  write_addr_i = 6'd0;
   logic [1:0]  write_size_i = 2'd0;
   logic [31:0] write_data_i = 32'd0;
   logic        write_error_o;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t       exp_q[$];
   int         n_chk  = 0;
   int         n_pass = 0;
   logic [7:0] mdl [64];

   data_memory #(.WIDTH(32), .DEPTH(16)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .read_en_i       (read_en_i),
      .read_addr_i     (read_addr_i),
      .read_size_i     (read_size_i),
      .read_unsigned_i (read_unsigned_i),
      .read_data_o     (read_data_o),
      .read_valid_o    (read_valid_o),
      .read_error_o    (read_error_o),
      .write_en_i      (write_en_i),
      .write_addr_i    (write_addr_i),
      .write_size_i    (write_size_i),
      .write_data_i    (write_data_i),
      .write_error_o   (write_error_o)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   function automatic logic mdl_legal(input logic [1:0] s, input logic [5:0] a);
      if (s == 2'd3) return 1'b0;
      return (a & ((6'd1 << s) - 6'd1)) == 6'd0;
   endfunction

   task automatic mdl_write(input logic [5:0] a, input logic [1:0] s, input logic [31:0] d);
      for (int i = 0; i < (1 << s); i++) mdl[int'(a) + i] = d[8*i +: 8];
   endtask

   task automatic mdl_load(input logic [5:0] a, input logic [1:0] s, input logic u,
                           output logic err, output logic [31:0] d);
      logic [31:0] v;
      int          n;
      v   = 32'd0;
      d   = 32'd0;
      err = !mdl_legal(s, a);
      if (!err) begin
         n = 1 << s;
         for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[int'(a) + i];
         if (!u && v[8*n-1]) begin
            for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
         end
         d = v;
      end
   endtask

   // One clock cycle: drive both ports, push the load expectation, then check.
   task automatic step(input logic rst,
                       input logic re, input logic [5:0] ra, input logic [1:0] rs, input logic ru,
                       input logic e_err, input logic [31:0] e_data,
                       input logic we, input logic [5:0] wa, input logic [1:0] ws, input logic [31:0] wd);
      exp_t e;
      logic e_werr;
      rst_i           = rst;
      read_en_i       = re;
      read_addr_i     = ra;
      read_size_i     = rs;
      read_unsigned_i = ru;
      write_en_i      = we;
      write_addr_i    = wa;
      write_size_i    = ws;
      write_data_i    = wd;
      if (re && !rst) exp_q.push_back('{err: e_err, data: e_data});
      e_werr = we && !rst && !mdl_legal(ws, wa);
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq("rvalid", 32'(read_valid_o), 32'd1);
         check_eq("rerr",   32'(read_error_o), 32'(e.err));
         check_eq("rdata",  read_data_o,       e.data);
      end else begin
         check_eq("rvalid_idle", 32'(read_valid_o), 32'd0);
      end
      check_eq("werr", 32'(write_error_o), 32'(e_werr));
      rst_i      = 1'b0;
      read_en_i  = 1'b0;
      write_en_i = 1'b0;
   endtask

   initial begin : stim
      logic        we, re, ru, e_err;
      logic [5:0]  wa, ra;
      logic [1:0]  ws, rs;
      logic [31:0] wd, e_data;

      // Reset state
      step(1'b1, 1'b0, 6'h00, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 6'h00, 2'd0, 32'h0);
      check_eq("rst_rdata", read_data_o, 32'h0);

      // Aligned store, sub-word loads
      step(1'b0, 1'b0, 6'h00, 2'd0, 1'b0, 1'b0, 32'h0,        1'b1, 6'h14, 2'd2, 32'h12345678);
      step(1'b0, 1'b1, 6'h14, 2'd2, 1'b0, 1'b0, 32'h12345678, 1'b0, 6'h00, 2'd0, 32'h0);
      step(1'b0, 1'b1, 6'h15, 2'd0, 1'b0, 1'b0, 32'h00000056, 1'b0, 6'h00, 2'd0, 32'h0);
      step(1'b0, 1'b1, 6'h16, 2'd1, 1'b1, 1'b0, 32'h00001234, 1'b0, 6'h00, 2'd0, 32'h0);

      // Byte-masked store and sign extension
      step(1'b0, 1'b0, 6'h00, 2'd0, 1'b0, 1'b0, 32'h0,        1'b1, 6'h16, 2'd0, 32'h00000080);
      step(1'b0, 1'b1, 6'h16, 2'd0, 1'b0, 1'b0, 32'hFFFFFF80, 1'b0, 6'h00, 2'd0, 32'h0);
      step(1'b0, 1'b1, 6'h16, 2'd0, 1'b1, 1'b0, 32'h00000080, 1'b0, 6'h00, 2'd0, 32'h0);
      step(1'b0, 1'b1, 6'h14, 2'd2, 1'b0, 1'b0, 32'h12805678, 1'b0, 6'h00, 2'd0, 32'h0);

      // Misaligned store: error pulse for one cycle, word 0x10 untouched
      step(1'b0, 1'b0, 6'h00, 2'd0, 1'b0, 1'b0, 32'h0,        1'b1, 6'h13, 2'd1, 32'h0000BEEF);
      step(1'b0, 1'b1, 6'h10, 2'd2, 1'b0, 1'b0, 32'h00000000, 1'b0, 6'h00, 2'd0, 32'h0);
      // Misaligned word load and illegal size
      step(1'b0, 1'b1, 6'h16, 2'd2, 1'b0, 1'b1, 32'h00000000, 1'b0, 6'h00, 2'd0, 32'h0);
      step(1'b0, 1'b1, 6'h10, 2'd3, 1'b0, 1'b1, 32'h00000000, 1'b0, 6'h00, 2'd0, 32'h0);

      // Collision: write-first on written lanes only
      step(1'b0, 1'b1, 6'h14, 2'd2, 1'b0, 1'b0, 32'h1280AAAA, 1'b1, 6'h14, 2'd1, 32'h0000AAAA);
      step(1'b0, 1'b0, 6'h00, 2'd0, 1'b0, 1'b0, 32'h0,        1'b1, 6'h14, 2'd1, 32'h00005678);
      // Rejected store is not bypassed
      step(1'b0, 1'b1, 6'h14, 2'd2, 1'b0, 1'b0, 32'h12805678, 1'b1, 6'h15, 2'd1, 32'h0000AAAA);

      // Pipelined loads after preloading 1..4
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b0, 6'h00, 2'd0, 1'b0, 1'b0, 32'h0, 1'b1, 6'(4 * i), 2'd2, 32'(i + 1));
      for (int i = 0; i < 4; i++)
         step(1'b0, 1'b1, 6'(4 * i), 2'd2, 1'b0, 1'b0, 32'(i + 1), 1'b0, 6'h00, 2'd0, 32'h0);

      // Reset mid-operation drops both requests and clears the array
      step(1'b1, 1'b1, 6'h00, 2'd2, 1'b0, 1'b0, 32'h0,        1'b1, 6'h00, 2'd0, 32'h000000FF);
      step(1'b0, 1'b1, 6'h00, 2'd2, 1'b0, 1'b0, 32'h00000000, 1'b0, 6'h00, 2'd0, 32'h0);
      step(1'b0, 1'b1, 6'h14, 2'd2, 1'b0, 1'b0, 32'h00000000, 1'b0, 6'h00, 2'd0, 32'h0);

      // Random traffic against the byte-array model
      for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
      for (int n = 0; n < 80; n++) begin
         we = 1'($urandom_range(0, 1));
         ws = 2'($urandom_range(0, 3));
         wa = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 3) != 0 && ws != 2'd3) wa = wa & ~((6'd1 << ws) - 6'd1);
         wd = $urandom;
         re = 1'($urandom_range(0, 1));
         rs = 2'($urandom_range(0, 3));
         ru = 1'($urandom_range(0, 1));
         ra = 6'($urandom_range(0, 63));
         if ($urandom_range(0, 2) == 0) ra = wa;
         if ($urandom_range(0, 3) != 0 && rs != 2'd3) ra = ra & ~((6'd1 << rs) - 6'd1);
         if (we && mdl_legal(ws, wa)) mdl_write(wa, ws, wd);
         mdl_load(ra, rs, ru, e_err, e_data);
         step(1'b0, re, ra, rs, ru, e_err, e_data, we, wa, ws, wd);
      end

      step(1'b0, 1'b0, 6'h00, 2'd0, 1'b0, 1'b0, 32'h0, 1'b0, 6'h00, 2'd0, 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressable, little-endian data memory for the core's load/store path.
- Successor to the word-only memory. Adds:
  - sub-word access (byte/half/word, and double when WIDTH=64) with sign or zero extension on loads;
  - byte-masked stores;
  - misalignment detection;
  - write-first bypass;
  - synchronous clear on reset.
- One read port and one write port, both usable every cycle.

Parameters:
- WIDTH, 32, word width in bits; legal values are 32 or 64.
- DEPTH, 16, number of words; power of two, at least 2.
- ADDR_W, $clog2(DEPTH*WIDTH/8), byte address width; derived, not overridden.

Ports:
- clk_i  input  1  clock; all activity on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- read_en_i  input  1  load request this cycle.
- read_addr_i  input  ADDR_W  byte address of the load.
- read_size_i  input  2  access size: 0=byte, 1=half, 2=word, 3=double.
- read_unsigned_i  input  1  1 = zero-extend result, 0 = sign-extend result.
- read_data_o  output  WIDTH  extended load result, registered.
- read_valid_o  output  1  read_data_o/read_error_o valid; one-cycle pulse per request.
- read_error_o  output  1  load was misaligned or used an illegal size.
- write_en_i  input  1  store request this cycle.
- write_addr_i  input  ADDR_W  byte address of the store.
- write_size_i  input  2  store size, same encoding as read_size_i.
- write_data_i  input  WIDTH  store data; only the low 8/16/32/64 bits are used.
- write_error_o  output  1  one-cycle pulse: previous-cycle store was rejected.

Behaviour:
- Reset:
  - rst_i high at an edge clears every word to 0.
  - read_data_o, read_valid_o, read_error_o and write_error_o all become 0.
  - Requests in the same cycle as rst_i are dropped: no write, no valid next cycle.
- Address split:
  - word index = addr >> log2(WIDTH/8);
  - byte offset = low log2(WIDTH/8) bits.
  - Byte lane k holds bits [8k+7:8k] (little-endian).
- Size legality:
  - size 3 is illegal when WIDTH=32.
  - An access is misaligned if its offset is not a multiple of its size in bytes.
  - Illegal or misaligned access means error.
- Load:
  - Latency is exactly 1 cycle: read_en_i at edge N gives read_valid_o=1 after edge N, for one cycle unless another request follows.
  - Good load: the selected bytes are right-aligned, then sign- or zero-extended to WIDTH per read_unsigned_i; read_error_o=0.
  - Error load: read_valid_o=1, read_error_o=1, read_data_o=0.
  - Back-to-back loads are fully pipelined: read_valid_o stays high on consecutive cycles.
  - With no request, read_valid_o=0. read_data_o holds its last value; do not rely on it.
- Store:
  - Committed at the edge where write_en_i=1.
  - Only the byte lanes covered by (offset, size) are updated; all other lanes are unchanged.
  - Store data is taken from the low bits of write_data_i and shifted to the target lane.
  - Error store: memory is unchanged and write_error_o=1 for the following cycle.
- Read/write collision:
  - Same cycle, same word index, both requests legal: the load returns post-write data per byte (write-first).
  - Lanes not written come from the array.
  - A rejected store is never bypassed.
- Read and write to different words in the same cycle are independent.
- No backpressure: both ports accept a request every cycle.

Test Plan:
- Aligned store and sub-word load:
  - store word 0x12345678 at addr 0x14 (size 2); next cycle load word at 0x14 → read_valid_o=1, read_data_o=0x12345678;
  - load byte signed at 0x15 → 0x00000056;
  - load half unsigned at 0x16 → 0x00001234.
- Sign extension and byte-masked store:
  - store byte 0x80 at 0x16; load byte signed at 0x16 → 0xFFFFFF80; load byte unsigned → 0x00000080;
  - load word at 0x14 → 0x12805678.
- Misalignment:
  - store half 0xBEEF at 0x13 → write_error_o=1 next cycle only; word at 0x10 unchanged;
  - load word at 0x16 → read_valid_o=1, read_error_o=1, read_data_o=0;
  - load size 3 with WIDTH=32 → error.
- Collision:
  - word 0x14 holds 0x12805678; same cycle: store half 0xAAAA at 0x14 and load word at 0x14 → 0x1280AAAA.
  - Repeat with a misaligned store at 0x15 → 0x12805678 and write_error_o=1.
- Pipelining:
  - four consecutive loads of words 0x0, 0x4, 0x8, 0xC preloaded with 1..4 → read_valid_o high four consecutive cycles, data 1, 2, 3, 4 in order.
- Reset mid-operation:
  - assert rst_i for one cycle together with read_en_i and write_en_i (store 0xFF at 0x0) → next cycle read_valid_o=0, write_error_o=0;
  - a subsequent word load at 0x0 and at 0x14 each return 0x00000000.
